// File: rtl/mem_req_scheduler_if.sv
// Requester and memory-port bundle of the memory request scheduler.
//  master : scheduler side (drives req_ready, proc2mem_*, rsp_*, busy, err_tag)
//  slave  : environment side (requesters plus the proc2mem/mem2proc memory port)
// Per-requester fields are packed: requester i owns req_addr[32*i+:32],
// req_data[64*i+:64] and req_idx[IDX_W*i+:IDX_W].
interface mem_req_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 6
);
    // requester side
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_store;
    logic [NUM_REQ*32-1:0]      req_addr;
    logic [NUM_REQ*64-1:0]      req_data;
    logic [NUM_REQ*IDX_W-1:0]   req_idx;
    logic [NUM_REQ-1:0]         req_ready;

    // memory port
    logic [3:0]                 mem2proc_transaction_tag;
    logic [63:0]                mem2proc_data;
    logic [3:0]                 mem2proc_data_tag;
    logic [1:0]                 proc2mem_command;
    logic [31:0]                proc2mem_addr;
    logic [63:0]                proc2mem_data;

    // load return and status
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [IDX_W-1:0]           rsp_idx;
    logic [63:0]                rsp_data;
    logic                       busy;
    logic                       err_tag;

    modport master (
        input  req_valid, req_store, req_addr, req_data, req_idx,
        input  mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
        output req_ready,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output rsp_valid, rsp_idx, rsp_data, busy, err_tag
    );

    modport slave (
        output req_valid, req_store, req_addr, req_data, req_idx,
        output mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
        input  req_ready,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  rsp_valid, rsp_idx, rsp_data, busy, err_tag
    );
endinterface

// File: rtl/mem_req_scheduler.sv
// Shares the single proc2mem/mem2proc memory port between NUM_REQ requesters.
// Round-robin grant in IDLE, one command held on the port in ISSUE until the
// memory returns a transaction tag, and a tag table that routes each returned
// block to the requester that issued the load, with its SRAM write index.
// Ports:
//  clk  : system clock
//  rst  : asynchronous reset, active-high
//  bus  : mem_req_scheduler_if.master (requests, memory port, responses, status)
// req_ready and busy are combinational; all other outputs come from registers.
module mem_req_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 6,
    parameter int unsigned MAX_OUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_req_scheduler_if.master  bus
);

    localparam int unsigned TAG_W    = 4;
    localparam int unsigned NUM_TAGS = 16;
    localparam int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W    = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_STORE = 2'd2
    } mem_cmd_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   id;
        logic [IDX_W-1:0]  idx;
    } tag_entry_t;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q;
    logic                iss_store_q;
    logic [31:0]         iss_addr_q;
    logic [63:0]         iss_data_q;
    logic [IDX_W-1:0]    iss_idx_q;
    logic [ID_W-1:0]     iss_id_q;
    tag_entry_t          tbl_q [NUM_TAGS];
    logic [CNT_W-1:0]    out_cnt_q;

    logic [NUM_REQ-1:0]  eligible;
    logic                pick_found;
    logic [ID_W-1:0]     pick_id;
    logic [ID_W-1:0]     cand;
    logic                capture;
    logic                accept;
    logic                accept_load;
    logic                rsp_hit;
    logic                rsp_miss;
    logic                new_slot;
    logic [TAG_W-1:0]    acc_tag;
    logic [TAG_W-1:0]    ret_tag;

    assign acc_tag = bus.mem2proc_transaction_tag;
    assign ret_tag = bus.mem2proc_data_tag;

    // Loads need a free tag slot; stores never occupy one.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = bus.req_valid[i] & (bus.req_store[i] | (out_cnt_q < MAX_CNT));
        end
    end

    // First eligible requester scanning upward from rr_ptr with wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!pick_found && eligible[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    assign accept      = (state_q == ST_ISSUE) && (acc_tag != '0);
    assign accept_load = accept && !iss_store_q;
    assign rsp_hit     = (ret_tag != '0) && tbl_q[ret_tag].valid;
    assign rsp_miss    = (ret_tag != '0) && !tbl_q[ret_tag].valid;

    // A load accept claims a new slot unless its tag is still live after this cycle's clear.
    assign new_slot = accept_load &&
                      !(tbl_q[acc_tag].valid && !(rsp_hit && (ret_tag == acc_tag)));

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and grant.
    always_comb begin
        state_d       = state_q;
        bus.req_ready = '0;
        capture       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    bus.req_ready[pick_id] = 1'b1;
                    capture                = 1'b1;
                    state_d                = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Issue registers and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            iss_store_q <= 1'b0;
            iss_addr_q  <= '0;
            iss_data_q  <= '0;
            iss_idx_q   <= '0;
            iss_id_q    <= '0;
        end else if (capture) begin
            rr_ptr_q    <= (pick_id == LAST_ID) ? '0 : pick_id + ID_W'(1);
            iss_store_q <= bus.req_store[pick_id];
            iss_addr_q  <= bus.req_addr[32*pick_id +: 32];
            iss_data_q  <= bus.req_data[64*pick_id +: 64];
            iss_idx_q   <= bus.req_idx[IDX_W*pick_id +: IDX_W];
            iss_id_q    <= pick_id;
        end
    end

    // Tag table: a returning tag is cleared before an accepted tag is written,
    // so a tag reused in the same cycle ends up holding the new load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned t = 0; t < NUM_TAGS; t++) begin
                tbl_q[t] <= '0;
            end
        end else begin
            if (rsp_hit) begin
                tbl_q[ret_tag].valid <= 1'b0;
            end
            if (accept_load) begin
                tbl_q[acc_tag] <= '{valid: 1'b1, id: iss_id_q, idx: iss_idx_q};
            end
        end
    end

    // Outstanding-load count, saturating at both ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt_q <= '0;
        end else if (new_slot && !rsp_hit) begin
            if (out_cnt_q != MAX_CNT) begin
                out_cnt_q <= out_cnt_q + CNT_W'(1);
            end
        end else if (rsp_hit && !new_slot) begin
            if (out_cnt_q != '0) begin
                out_cnt_q <= out_cnt_q - CNT_W'(1);
            end
        end
    end

    // Response routing: single-cycle pulse to the owner of the returned tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid <= '0;
            bus.rsp_idx   <= '0;
            bus.rsp_data  <= '0;
            bus.err_tag   <= 1'b0;
        end else begin
            bus.rsp_valid <= '0;
            if (rsp_hit) begin
                bus.rsp_valid <= NUM_REQ'(1) << tbl_q[ret_tag].id;
                bus.rsp_idx   <= tbl_q[ret_tag].idx;
                bus.rsp_data  <= bus.mem2proc_data;
            end
            if (rsp_miss) begin
                bus.err_tag <= 1'b1;
            end
        end
    end

    // Port drive straight from the issue registers; NONE outside ISSUE.
    assign bus.proc2mem_command = (state_q == ST_ISSUE) ?
                                  (iss_store_q ? CMD_STORE : CMD_LOAD) : CMD_NONE;
    assign bus.proc2mem_addr    = iss_addr_q;
    assign bus.proc2mem_data    = iss_data_q;
    assign bus.busy             = (state_q == ST_ISSUE) || (out_cnt_q != '0);

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Directed bench for mem_req_scheduler with hand-computed expectations.
module tb_mem_req_scheduler;

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    mem_req_scheduler_if #(.NUM_REQ(4), .IDX_W(6)) bus ();

    mem_req_scheduler #(.NUM_REQ(4), .IDX_W(6), .MAX_OUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        bus.req_valid                = '0;
        bus.req_store                = '0;
        bus.req_addr                 = '0;
        bus.req_data                 = '0;
        bus.req_idx                  = '0;
        bus.mem2proc_transaction_tag = '0;
        bus.mem2proc_data            = '0;
        bus.mem2proc_data_tag        = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
    endtask

    // Single-requester command: grant, one ISSUE cycle, accepted with tag tg.
    task automatic do_req(input int r, input logic st, input logic [31:0] a,
                          input logic [5:0] ix, input logic [63:0] d, input logic [3:0] tg);
        bus.req_store[r]         = st;
        bus.req_addr[32*r +: 32] = a;
        bus.req_data[64*r +: 64] = d;
        bus.req_idx[6*r +: 6]    = ix;
        bus.req_valid            = 4'(1 << r);
        #1;
        check("grant", 64'(bus.req_ready), 64'(4'(1 << r)));
        tick();
        bus.req_valid = '0;
        #1;
        check("cmd", 64'(bus.proc2mem_command), st ? 64'd2 : 64'd1);
        check("addr", 64'(bus.proc2mem_addr), 64'(a));
        bus.mem2proc_transaction_tag = tg;
        tick();
        bus.mem2proc_transaction_tag = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  exp_rsp [5];
        logic [3:0]  exp_gnt;
        logic [31:0] exp_addr;

        // Reset state
        rst = 1'b1;
        clear_inputs();
        tick();
        #1;
        check("rst_cmd",  64'(bus.proc2mem_command), 64'd0);
        check("rst_addr", 64'(bus.proc2mem_addr), 64'd0);
        check("rst_rspv", 64'(bus.rsp_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_err",  64'(bus.err_tag), 64'd0);
        check("rst_rdy",  64'(bus.req_ready), 64'd0);
        rst = 1'b0;
        tick();

        // Single load, accepted after 2 wait cycles, data returned on tag 3
        bus.req_addr[31:0] = 32'h100;
        bus.req_idx[5:0]   = 6'd5;
        bus.req_valid      = 4'b0001;
        #1;
        check("t1_grant", 64'(bus.req_ready), 64'h1);
        check("t1_cmd_idle", 64'(bus.proc2mem_command), 64'd0);
        tick();
        bus.req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t1_cmd_hold", 64'(bus.proc2mem_command), 64'd1);
            check("t1_addr_hold", 64'(bus.proc2mem_addr), 64'h100);
            if (c == 2) bus.mem2proc_transaction_tag = 4'd3;
            tick();
        end
        bus.mem2proc_transaction_tag = '0;
        #1;
        check("t1_cmd_none", 64'(bus.proc2mem_command), 64'd0);
        check("t1_busy_out", 64'(bus.busy), 64'd1);
        bus.mem2proc_data_tag = 4'd3;
        bus.mem2proc_data     = 64'hDEAD;
        #1;
        check("t1_rsp_early", 64'(bus.rsp_valid), 64'h0);
        tick();
        bus.mem2proc_data_tag = '0;
        #1;
        check("t1_rspv", 64'(bus.rsp_valid), 64'h1);
        check("t1_rspidx", 64'(bus.rsp_idx), 64'd5);
        check("t1_rspdata", bus.rsp_data, 64'hDEAD);
        check("t1_busy_done", 64'(bus.busy), 64'd0);
        tick();
        #1;
        check("t1_rsp_pulse", 64'(bus.rsp_valid), 64'h0);

        // All four requesters valid; round-robin 0,1,2,3,0 with req3 a store
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.req_addr[32*i +: 32] = 32'h1000 + 32'(16 * i);
            bus.req_data[64*i +: 64] = 64'h1111 * 64'(i + 1);
            bus.req_idx[6*i +: 6]    = 6'(10 + i);
        end
        bus.req_data[255:192] = 64'hCAFE_F00D_1234_5678;
        bus.req_store         = 4'b1000;
        bus.req_valid         = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_gnt  = 4'(1 << (g % 4));
            exp_addr = 32'h1000 + 32'(16 * (g % 4));
            #1;
            check("t2_grant", 64'(bus.req_ready), 64'(exp_gnt));
            tick();
            #1;
            check("t2_cmd", 64'(bus.proc2mem_command), (g % 4 == 3) ? 64'd2 : 64'd1);
            check("t2_addr", 64'(bus.proc2mem_addr), 64'(exp_addr));
            if (g % 4 == 3) check("t2_sdata", bus.proc2mem_data, 64'hCAFE_F00D_1234_5678);
            bus.mem2proc_transaction_tag = 4'(g + 1);
            if (g == 4) bus.req_valid = '0;
            tick();
            bus.mem2proc_transaction_tag = '0;
        end
        exp_rsp[0] = 4'b0001;
        exp_rsp[1] = 4'b0010;
        exp_rsp[2] = 4'b0100;
        exp_rsp[3] = 4'b0000;
        exp_rsp[4] = 4'b0001;
        for (int t = 0; t < 5; t++) begin
            if (t == 3) continue;
            bus.mem2proc_data_tag = 4'(t + 1);
            bus.mem2proc_data     = 64'hA0 + 64'(t);
            tick();
            bus.mem2proc_data_tag = '0;
            #1;
            check("t2_rspv", 64'(bus.rsp_valid), 64'(exp_rsp[t]));
            check("t2_rspdata", bus.rsp_data, 64'hA0 + 64'(t));
        end
        check("t2_busy_done", 64'(bus.busy), 64'd0);
        check("t2_err", 64'(bus.err_tag), 64'd0);

        // Fill 15 outstanding loads; store still granted, load blocked until a slot frees
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            do_req(0, 1'b0, 32'h2000 + 32'(8 * i), 6'(i), 64'd0, 4'(i));
        end
        bus.req_store[1]      = 1'b0;
        bus.req_addr[63:32]   = 32'h3000;
        bus.req_idx[11:6]     = 6'd20;
        bus.req_store[3]      = 1'b1;
        bus.req_addr[127:96]  = 32'h4000;
        bus.req_data[255:192] = 64'h77;
        bus.req_valid         = 4'b1010;
        #1;
        check("t3_store_gnt", 64'(bus.req_ready), 64'b1000);
        tick();
        bus.req_valid = 4'b0010;
        #1;
        check("t3_store_cmd", 64'(bus.proc2mem_command), 64'd2);
        check("t3_store_addr", 64'(bus.proc2mem_addr), 64'h4000);
        bus.mem2proc_transaction_tag = 4'd7;
        tick();
        bus.mem2proc_transaction_tag = '0;
        #1;
        check("t3_load_blocked", 64'(bus.req_ready), 64'h0);
        bus.mem2proc_data_tag = 4'd4;
        bus.mem2proc_data     = 64'h44;
        tick();
        bus.mem2proc_data_tag = '0;
        #1;
        check("t3_rspv", 64'(bus.rsp_valid), 64'b0001);
        check("t3_rspidx", 64'(bus.rsp_idx), 64'd4);
        check("t3_load_gnt", 64'(bus.req_ready), 64'b0010);
        tick();
        bus.req_valid = '0;
        #1;
        check("t3_load_cmd", 64'(bus.proc2mem_command), 64'd1);
        check("t3_load_addr", 64'(bus.proc2mem_addr), 64'h3000);
        bus.mem2proc_transaction_tag = 4'd4;
        tick();
        bus.mem2proc_transaction_tag = '0;
        #1;
        check("t3_busy", 64'(bus.busy), 64'd1);

        // Out-of-order returns
        do_reset();
        do_req(1, 1'b0, 32'h500, 6'd7, 64'd0, 4'd2);
        do_req(2, 1'b0, 32'h600, 6'd1, 64'd0, 4'd9);
        bus.mem2proc_data_tag = 4'd9;
        bus.mem2proc_data     = 64'h99;
        tick();
        bus.mem2proc_data_tag = 4'd2;
        bus.mem2proc_data     = 64'h22;
        #1;
        check("t4_rspv_a", 64'(bus.rsp_valid), 64'b0100);
        check("t4_idx_a", 64'(bus.rsp_idx), 64'd1);
        check("t4_data_a", bus.rsp_data, 64'h99);
        check("t4_busy_mid", 64'(bus.busy), 64'd1);
        tick();
        bus.mem2proc_data_tag = '0;
        #1;
        check("t4_rspv_b", 64'(bus.rsp_valid), 64'b0010);
        check("t4_idx_b", 64'(bus.rsp_idx), 64'd7);
        check("t4_data_b", bus.rsp_data, 64'h22);
        check("t4_busy_end", 64'(bus.busy), 64'd0);

        // Same-cycle return of tag 4 and accept of a new load on tag 4
        do_reset();
        do_req(0, 1'b0, 32'h700, 6'd3, 64'd0, 4'd4);
        bus.req_store[2]     = 1'b0;
        bus.req_addr[95:64]  = 32'h800;
        bus.req_idx[17:12]   = 6'd9;
        bus.req_valid        = 4'b0100;
        #1;
        check("t5_grant", 64'(bus.req_ready), 64'b0100);
        tick();
        bus.req_valid                = '0;
        bus.mem2proc_transaction_tag = 4'd4;
        bus.mem2proc_data_tag        = 4'd4;
        bus.mem2proc_data            = 64'hAAAA;
        tick();
        bus.mem2proc_transaction_tag = '0;
        bus.mem2proc_data_tag        = 4'd4;
        bus.mem2proc_data            = 64'hBBBB;
        #1;
        check("t5_old_rspv", 64'(bus.rsp_valid), 64'b0001);
        check("t5_old_idx", 64'(bus.rsp_idx), 64'd3);
        check("t5_old_data", bus.rsp_data, 64'hAAAA);
        check("t5_busy", 64'(bus.busy), 64'd1);
        tick();
        bus.mem2proc_data_tag = 4'd11;
        #1;
        check("t5_new_rspv", 64'(bus.rsp_valid), 64'b0100);
        check("t5_new_idx", 64'(bus.rsp_idx), 64'd9);
        check("t5_cnt_zero", 64'(bus.busy), 64'd0);
        check("t5_err_before", 64'(bus.err_tag), 64'd0);
        tick();
        bus.mem2proc_data_tag = '0;
        #1;
        check("t5_unk_rspv", 64'(bus.rsp_valid), 64'h0);
        check("t5_err", 64'(bus.err_tag), 64'd1);
        tick();
        #1;
        check("t5_err_sticky", 64'(bus.err_tag), 64'd1);

        // Reset during ISSUE with two loads outstanding
        do_reset();
        do_req(0, 1'b0, 32'h900, 6'd1, 64'd0, 4'd1);
        do_req(1, 1'b0, 32'hA00, 6'd2, 64'd0, 4'd2);
        bus.req_store[2]    = 1'b0;
        bus.req_addr[95:64] = 32'hB00;
        bus.req_valid       = 4'b0100;
        tick();
        bus.req_valid = '0;
        #1;
        check("t6_issue_cmd", 64'(bus.proc2mem_command), 64'd1);
        check("t6_busy_pre", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_cmd", 64'(bus.proc2mem_command), 64'd0);
        check("t6_rst_busy", 64'(bus.busy), 64'd0);
        tick();
        rst = 1'b0;
        bus.mem2proc_data_tag = 4'd1;
        bus.mem2proc_data     = 64'h55;
        tick();
        bus.mem2proc_data_tag = '0;
        #1;
        check("t6_stale_rspv", 64'(bus.rsp_valid), 64'h0);
        check("t6_stale_err", 64'(bus.err_tag), 64'd1);
        check("t6_busy_post", 64'(bus.busy), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
